// File: rtl/cdr_package.sv
// rtl/cdr_package.sv - CDR types, widths, default loop gains and saturation helpers
// Provides CDR_ADJ_WIDTH/CDR_ADJ_FORMAT, INTEG_WIDTH/integ_t, default KP/KI/INT_SHIFT,
// and clamp functions from a 32-bit signed intermediate to the integrator / adjust widths.
package cdr_package;

  localparam int CDR_ADJ_WIDTH     = 16;
  localparam int INTEG_WIDTH       = 24;
  localparam int KP_DEFAULT        = 16;
  localparam int KI_DEFAULT        = 4;
  localparam int INT_SHIFT_DEFAULT = 8;

  typedef logic signed [CDR_ADJ_WIDTH-1:0] CDR_ADJ_FORMAT;
  typedef logic signed [INTEG_WIDTH-1:0]   integ_t;

  // Loop arithmetic is done at 32 bits, which leaves ample headroom above
  // both target widths for the gains used here.
  localparam logic signed [31:0] INTEG_MAX = (32'sd1 <<< (INTEG_WIDTH-1)) - 32'sd1;
  localparam logic signed [31:0] INTEG_MIN = -(32'sd1 <<< (INTEG_WIDTH-1));
  localparam logic signed [31:0] ADJ_MAX   = (32'sd1 <<< (CDR_ADJ_WIDTH-1)) - 32'sd1;
  localparam logic signed [31:0] ADJ_MIN   = -(32'sd1 <<< (CDR_ADJ_WIDTH-1));

  function automatic integ_t sat_integ(input logic signed [31:0] x);
    if (x > INTEG_MAX) begin
      return INTEG_MAX[INTEG_WIDTH-1:0];
    end else if (x < INTEG_MIN) begin
      return INTEG_MIN[INTEG_WIDTH-1:0];
    end
    return x[INTEG_WIDTH-1:0];
  endfunction

  function automatic CDR_ADJ_FORMAT sat_adj(input logic signed [31:0] x);
    if (x > ADJ_MAX) begin
      return ADJ_MAX[CDR_ADJ_WIDTH-1:0];
    end else if (x < ADJ_MIN) begin
      return ADJ_MIN[CDR_ADJ_WIDTH-1:0];
    end
    return x[CDR_ADJ_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/filter_package.sv
// rtl/filter_package.sv - channel/CTLE filter output format shared with downstream receiver blocks
// Provides FILTER_OUT_WIDTH and the signed FILTER_OUT_FORMAT sample type.
package filter_package;

  localparam int FILTER_OUT_WIDTH = 16;

  typedef logic signed [FILTER_OUT_WIDTH-1:0] FILTER_OUT_FORMAT;

endpackage

// File: rtl/cdr_loop_filter.sv
// rtl/cdr_loop_filter.sv - saturating proportional-integral loop filter for bang-bang CDR
// Ports: clk_sys, rst (async, active-high); pd_valid_i qualifies one PD result per data
// strobe; pd_i is the signed decision (+1 up, -1 dn, 0 none); rx_inc_adj_o is the
// saturated signed clock increment adjustment.
module cdr_loop_filter
  import cdr_package::*;
#(
  parameter int KP        = KP_DEFAULT,
  parameter int KI        = KI_DEFAULT,
  parameter int INT_SHIFT = INT_SHIFT_DEFAULT
) (
  input  logic                            clk_sys,
  input  logic                            rst,
  input  logic                            pd_valid_i,
  input  logic signed [1:0]               pd_i,
  output logic signed [CDR_ADJ_WIDTH-1:0] rx_inc_adj_o
);

  localparam logic signed [31:0] KP_S = 32'(KP);
  localparam logic signed [31:0] KI_S = 32'(KI);

  integ_t        integ_q, integ_d;
  CDR_ADJ_FORMAT adj_q, adj_d;

  logic signed [31:0] pd_ext;
  logic signed [31:0] integ_ext;
  logic signed [31:0] integ_sum;
  integ_t             integ_new;
  logic signed [31:0] integ_new_ext;
  logic signed [31:0] adj_sum;

  always_comb begin
    pd_ext        = {{30{pd_i[1]}}, pd_i};
    integ_ext     = {{(32-INTEG_WIDTH){integ_q[INTEG_WIDTH-1]}}, integ_q};
    integ_sum     = integ_ext + KI_S * pd_ext;
    // A zero decision leaves the integrator alone but still refreshes the
    // output, which drops the proportional kick of the previous decision.
    integ_new     = (pd_i != 2'sb00) ? sat_integ(integ_sum) : integ_q;
    integ_new_ext = {{(32-INTEG_WIDTH){integ_new[INTEG_WIDTH-1]}}, integ_new};
    adj_sum       = (integ_new_ext >>> INT_SHIFT) + KP_S * pd_ext;

    integ_d = integ_q;
    adj_d   = adj_q;
    if (pd_valid_i) begin
      integ_d = integ_new;
      adj_d   = sat_adj(adj_sum);
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      integ_q <= '0;
      adj_q   <= '0;
    end else begin
      integ_q <= integ_d;
      adj_q   <= adj_d;
    end
  end

  assign rx_inc_adj_o = adj_q;

endmodule

// File: rtl/rx_cdr.sv
// rtl/rx_cdr.sv - bang-bang CDR: slicer, Alexander phase detector, PI loop filter, lock detect
// Ports: clk_sys, rst (async, active-high); sig_rx signed filter output; cke_rx_p data
// strobe; cke_rx_n edge strobe; data_out/data_valid recovered bit; up/dn PD pulses;
// rx_inc_adj signed clock increment adjustment; lock windowed lock flag; err sticky
// flag for coincident data and edge strobes.
module rx_cdr
  import filter_package::*;
  import cdr_package::*;
#(
  parameter int KP          = KP_DEFAULT,
  parameter int KI          = KI_DEFAULT,
  parameter int INT_SHIFT   = INT_SHIFT_DEFAULT,
  parameter int LOCK_WINDOW = 256,
  parameter int LOCK_THRESH = 8
) (
  input  logic                               clk_sys,
  input  logic                               rst,
  input  logic signed [FILTER_OUT_WIDTH-1:0] sig_rx,
  input  logic                               cke_rx_p,
  input  logic                               cke_rx_n,
  output logic                               data_out,
  output logic                               data_valid,
  output logic                               up,
  output logic                               dn,
  output logic signed [CDR_ADJ_WIDTH-1:0]    rx_inc_adj,
  output logic                               lock,
  output logic                               err
);

  localparam int WIN_BITS = $clog2(LOCK_WINDOW);
  localparam int SUM_W    = WIN_BITS + 2;

  localparam logic [WIN_BITS-1:0] WIN_LAST = WIN_BITS'(LOCK_WINDOW - 1);
  localparam logic [SUM_W-1:0]    THRESH_V = SUM_W'(LOCK_THRESH);
  localparam FILTER_OUT_FORMAT    SIG_ZERO = '0;

  // ---------------- slicer and phase detector (results at t+1) ----------------
  logic data_out_q, data_out_d;
  logic data_valid_q, data_valid_d;
  logic up_q, up_d;
  logic dn_q, dn_d;
  logic trans_q, trans_d;
  logic d_prev_q, d_prev_d;
  logic prev_vld_q, prev_vld_d;
  logic e_q, e_d;
  logic edge_vld_q, edge_vld_d;
  logic err_q, err_d;
  logic slice;

  always_comb begin
    slice = (sig_rx >= SIG_ZERO);

    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    up_d         = 1'b0;
    dn_d         = 1'b0;
    trans_d      = 1'b0;
    d_prev_d     = d_prev_q;
    prev_vld_d   = prev_vld_q;
    e_d          = e_q;
    edge_vld_d   = edge_vld_q;
    err_d        = err_q;

    if (cke_rx_p && cke_rx_n) begin
      // Ambiguous sample: drop both strobes entirely and flag it.
      err_d = 1'b1;
    end else if (cke_rx_n) begin
      e_d        = slice;
      edge_vld_d = 1'b1;
    end else if (cke_rx_p) begin
      data_out_d   = slice;
      data_valid_d = 1'b1;
      if (prev_vld_q && (d_prev_q != slice)) begin
        trans_d = 1'b1;
        // On a transition the edge bit matches exactly one neighbour: matching
        // the new bit means the edge was sampled late.
        if (edge_vld_q) begin
          up_d = (e_q == slice);
          dn_d = (e_q != slice);
        end
      end
      d_prev_d   = slice;
      prev_vld_d = 1'b1;
      edge_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      data_out_q   <= 1'b0;
      data_valid_q <= 1'b0;
      up_q         <= 1'b0;
      dn_q         <= 1'b0;
      trans_q      <= 1'b0;
      d_prev_q     <= 1'b0;
      prev_vld_q   <= 1'b0;
      e_q          <= 1'b0;
      edge_vld_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      up_q         <= up_d;
      dn_q         <= dn_d;
      trans_q      <= trans_d;
      d_prev_q     <= d_prev_d;
      prev_vld_q   <= prev_vld_d;
      e_q          <= e_d;
      edge_vld_q   <= edge_vld_d;
      err_q        <= err_d;
    end
  end

  logic signed [1:0] pd;
  assign pd = up_q ? 2'sb01 : (dn_q ? 2'sb11 : 2'sb00);

  // ---------------- loop filter (results at t+2) ----------------
  cdr_loop_filter #(
    .KP        (KP),
    .KI        (KI),
    .INT_SHIFT (INT_SHIFT)
  ) u_loop_filter (
    .clk_sys      (clk_sys),
    .rst          (rst),
    .pd_valid_i   (data_valid_q),
    .pd_i         (pd),
    .rx_inc_adj_o (rx_inc_adj)
  );

  // ---------------- lock detector (results at t+2) ----------------
  logic [WIN_BITS-1:0]    win_cnt_q, win_cnt_d;
  logic signed [SUM_W-1:0] pd_sum_q, pd_sum_d;
  logic                   trans_seen_q, trans_seen_d;
  logic                   lock_q, lock_d;
  logic signed [SUM_W-1:0] pd_sum_new;
  logic [SUM_W-1:0]       pd_abs;
  logic                   trans_new;

  always_comb begin
    pd_sum_new = pd_sum_q + {{(SUM_W-2){pd[1]}}, pd};
    pd_abs     = pd_sum_new[SUM_W-1] ? (-pd_sum_new) : pd_sum_new;
    trans_new  = trans_seen_q | trans_q;

    win_cnt_d    = win_cnt_q;
    pd_sum_d     = pd_sum_q;
    trans_seen_d = trans_seen_q;
    lock_d       = lock_q;

    if (data_valid_q) begin
      if (win_cnt_q == WIN_LAST) begin
        // A window with no data transitions carries no phase information,
        // so a quiet detector alone is not evidence of lock.
        lock_d       = (pd_abs <= THRESH_V) && trans_new;
        win_cnt_d    = '0;
        pd_sum_d     = '0;
        trans_seen_d = 1'b0;
      end else begin
        win_cnt_d    = win_cnt_q + WIN_BITS'(1);
        pd_sum_d     = pd_sum_new;
        trans_seen_d = trans_new;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      win_cnt_q    <= '0;
      pd_sum_q     <= '0;
      trans_seen_q <= 1'b0;
      lock_q       <= 1'b0;
    end else begin
      win_cnt_q    <= win_cnt_d;
      pd_sum_q     <= pd_sum_d;
      trans_seen_q <= trans_seen_d;
      lock_q       <= lock_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign up         = up_q;
  assign dn         = dn_q;
  assign lock       = lock_q;
  assign err        = err_q;

endmodule

// File: doc/rx_cdr.md
# rx_cdr

Bang-bang clock-and-data-recovery controller for the emulated receiver, directly downstream of the channel/CTLE filter. Slices the filter output at the RX data and edge sample strobes, forms Alexander phase-detector decisions (up/dn), and runs a saturating proportional-integral digital loop filter. The loop filter produces a signed increment adjustment for the RX `const_clock`, closing the timing-recovery loop in emulated time. Also emits recovered bits and a windowed lock flag.

## Interface
Parameters:
- KP, 16: proportional gain applied per PD decision (signed adj LSBs).
- KI, 4: integral gain added to the integrator per PD decision.
- INT_SHIFT, 8: right arithmetic shift from integrator to adjustment domain.
- LOCK_WINDOW, 256: data samples per lock-evaluation window (power of two).
- LOCK_THRESH, 8: maximum |sum of PD decisions| per window to declare lock.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- rst  in  1  **reset is asynchronous and active-high; one clock, `clk_sys`**.
- sig_rx  in  FILTER_OUT_WIDTH  signed filter output (FILTER_OUT_FORMAT).
- cke_rx_p  in  1  data-sample strobe (one `clk_sys` cycle per UI).
- cke_rx_n  in  1  edge-sample strobe (one cycle, between data strobes).
- data_out  out  1  recovered bit.
- data_valid  out  1  one-cycle pulse qualifying data_out.
- up  out  1  one-cycle pulse: clock late, advance phase.
- dn  out  1  one-cycle pulse: clock early, retard phase.
- rx_inc_adj  out  CDR_ADJ_WIDTH  signed adjustment added to RX_INC (CDR_ADJ_FORMAT).
- lock  out  1  lock indicator, updated at window end.
- err  out  1  sticky protocol-violation flag.

## Operation
- Slicer: bit = 1 when sig_rx >= 0 (MSB clear), else 0.
- cke_rx_n alone: latch edge bit e, set edge_vld. A second edge before a data strobe overwrites e.
- cke_rx_p alone: new data bit d_n; emit data_out=d_n, data_valid=1.
  - PD decision only when prev_vld and edge_vld:
    - d_prev != d_n and e == d_n: up (pd=+1).
    - d_prev != d_n and e == d_prev: dn (pd=-1).
    - Otherwise pd=0.
  - Then d_prev<=d_n, prev_vld<=1, edge_vld<=0.
- cke_rx_p and cke_rx_n in same cycle: both ignored; no PD decision, no data_valid; err<=1 (sticky until rst).
- Loop filter, on each nonzero pd:
  - integ (INTEG_WIDTH=24 signed) <= sat24(integ + KI*pd).
  - rx_inc_adj <= sat(CDR_ADJ_WIDTH)((integ_new >>> INT_SHIFT) + KP*pd).
  - On pd=0 strobes, rx_inc_adj <= sat((integ >>> INT_SHIFT)), dropping the proportional kick.
- Saturation clamps to the signed min/max of the target width; never wraps.
- Lock:
  - Window counter increments per accepted data strobe; pd_sum accumulates pd (signed, log2(LOCK_WINDOW)+2 bits).
  - At window end: lock <= (|pd_sum| <= LOCK_THRESH) && (transitions in window >= 1); counters clear.

## Timing
- Reset values: data_out=0, data_valid=0, up=0, dn=0, rx_inc_adj=0, lock=0, err=0; integ=0; prev_vld=edge_vld=0; counters 0.
- Reset mid-operation clears all state immediately (async); the first data strobe after release never yields a PD decision.
- Data strobe in cycle t: data_out/data_valid/up/dn registered at t+1 (single-cycle pulses).
- integ and rx_inc_adj update at t+2.
- lock updates at t+2 of the final strobe of a window.
- Back-to-back strobes every cycle are supported at full throughput.

## Structure
- New `cdr_package`: CDR_ADJ_WIDTH=16, typedef CDR_ADJ_FORMAT (signed), INTEG_WIDTH=24, default KP/KI/INT_SHIFT.
- FILTER_OUT_FORMAT/WIDTH come from filter_package.
- Sub-module `cdr_loop_filter`: pd in (2-bit signed + valid), integrator, saturation, rx_inc_adj out. The PD, slicer, and lock logic stay in rx_cdr.

## Test plan
- Alternating data (+100/-100), edge sample equal to new data each UI: up pulses every UI. After 10 decisions (KP=16, KI=4, INT_SHIFT=0), integ=40 and rx_inc_adj=56.
- Same pattern with edge equal to previous data: dn pulses; rx_inc_adj=-56 after 10 decisions. Sustained drive saturates at -32768 with no wrap.
- Constant +50 data: data_out=1, no up/dn, rx_inc_adj holds at 0. lock stays 0 (no transitions) after 256 samples.
- Alternating up/dn decisions over 256 samples: pd_sum=0, so lock=1 at t+2 of the 256th strobe.
- cke_rx_p and cke_rx_n asserted together: err=1, no data_valid. err persists until rst. rst mid-stream zeroes rx_inc_adj asynchronously.
- First data after reset with an edge present: data_valid=1, no up/dn.
